// File: rtl/bus_term_pkg.sv
// Shared definitions for the bus terminal port.
//   ID_W         : width of the destination ID field
//   BROADCAST_ID : destination ID accepted by every terminal
//   CNT_W        : width of the misroute statistics counter
//   MAX_PKT_W    : widest packet get_dest() can take
//   get_dest()   : extracts the destination ID from the top ID_W bits of a packet
package bus_term_pkg;

  localparam int unsigned ID_W      = 8;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_PKT_W = 256;

  // The packet is passed zero-extended to MAX_PKT_W together with its real
  // width, so one function serves any ANCHO up to MAX_PKT_W.
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                               input int unsigned pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_terminal_port_fifo.sv
// port_fifo: show-ahead synchronous FIFO (circular buffer, any DEPTH >= 2).
//   push/din   : write request and data; accepted when not full, or when full
//                together with a pop
//   pop        : consume head; ignored when empty
//   dout       : head entry, '0 when empty
//   count      : occupancy; full/empty derived from it
//   ovf_pulse  : push dropped this cycle (full, no pop)
//   unf_pulse  : pop requested while empty
module port_fifo
  import bus_term_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_pulse,
  output logic                       unf_pulse
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    do_pop    = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    do_push   = push && (!full || pop);
    ovf_pulse = push && full && !pop;
    unf_pulse = pop && empty;

    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    count = count_q;
    dout  = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/bus_terminal_port.sv
// bus_terminal_port: per-terminal bus endpoint.
//   TX : wr_en/wr_data -> TX FIFO -> pndng/D_pop (show-ahead), pop from arbiter
//   RX : push/D_push filtered on destination ID (ID or BROADCAST) -> RX FIFO
//        -> rx_valid/rx_data (show-ahead), rx_rd from agent
//   Status : sticky tx_overflow/tx_underflow/rx_overflow, saturating misroute_cnt
module bus_terminal_port
  import bus_term_pkg::*;
#(
  parameter int unsigned ANCHO       = 32,
  parameter int unsigned PROFUNDIDAD = 8,
  parameter int unsigned RX_PROF     = 8,
  parameter logic [7:0]  ID          = 8'd0,
  parameter logic [7:0]  BROADCAST   = BROADCAST_ID
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ANCHO-1:0]                 wr_data,
  output logic                             tx_full,
  output logic [$clog2(PROFUNDIDAD+1)-1:0] tx_count,
  output logic                             pndng,
  output logic [ANCHO-1:0]                 D_pop,
  input  logic                             pop,
  input  logic                             push,
  input  logic [ANCHO-1:0]                 D_push,
  output logic                             rx_valid,
  output logic [ANCHO-1:0]                 rx_data,
  input  logic                             rx_rd,
  output logic                             tx_overflow,
  output logic                             tx_underflow,
  output logic                             rx_overflow,
  output logic [15:0]                      misroute_cnt
);

  logic                           tx_empty, tx_ovf, tx_unf;
  logic                           rx_empty, rx_full, rx_ovf, rx_unf;
  logic [$clog2(RX_PROF+1)-1:0]   rx_count;
  logic                           rx_unused;
  logic [ID_W-1:0]                dest;
  logic                           accept, misroute;

  logic             tx_overflow_q, tx_overflow_d;
  logic             tx_underflow_q, tx_underflow_d;
  logic             rx_overflow_q, rx_overflow_d;
  logic [CNT_W-1:0] misroute_q, misroute_d;

  port_fifo #(.WIDTH(ANCHO), .DEPTH(PROFUNDIDAD)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .pop       (pop),
    .din       (wr_data),
    .dout      (D_pop),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .ovf_pulse (tx_ovf),
    .unf_pulse (tx_unf)
  );

  port_fifo #(.WIDTH(ANCHO), .DEPTH(RX_PROF)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (rx_rd),
    .din       (D_push),
    .dout      (rx_data),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .ovf_pulse (rx_ovf),
    .unf_pulse (rx_unf)
  );

  // RX occupancy and read-while-empty are not reported at this level.
  assign rx_unused = ^{rx_count, rx_full, rx_unf};

  always_comb begin
    dest     = get_dest(MAX_PKT_W'(D_push), ANCHO);
    accept   = push && ((dest == ID) || (dest == BROADCAST));
    misroute = push && !accept;

    tx_overflow_d  = tx_overflow_q  | tx_ovf;
    tx_underflow_d = tx_underflow_q | tx_unf;
    rx_overflow_d  = rx_overflow_q  | rx_ovf;
    misroute_d     = (misroute && (misroute_q != '1)) ? misroute_q + CNT_W'(1) : misroute_q;

    pndng        = !tx_empty;
    rx_valid     = !rx_empty;
    tx_overflow  = tx_overflow_q;
    tx_underflow = tx_underflow_q;
    rx_overflow  = rx_overflow_q;
    misroute_cnt = misroute_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
      rx_overflow_q  <= 1'b0;
      misroute_q     <= '0;
    end else begin
      tx_overflow_q  <= tx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
      rx_overflow_q  <= rx_overflow_d;
      misroute_q     <= misroute_d;
    end
  end

endmodule

// File: tb/tb_bus_terminal_port.sv
module tb_bus_terminal_port;

  localparam int unsigned DEPTH_TX = 8;
  localparam int unsigned DEPTH_RX = 8;
  localparam logic [7:0]  MY_ID    = 8'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [31:0] D_pop;
  logic        pop;
  logic        push;
  logic [31:0] D_push;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_rd;
  logic        tx_overflow, tx_underflow, rx_overflow;
  logic [15:0] misroute_cnt;

  always #5 clk = ~clk;

  bus_terminal_port #(
    .ANCHO(32), .PROFUNDIDAD(DEPTH_TX), .RX_PROF(DEPTH_RX), .ID(MY_ID), .BROADCAST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_overflow(tx_overflow), .tx_underflow(tx_underflow), .rx_overflow(rx_overflow),
    .misroute_cnt(misroute_cnt)
  );

  // Reference model: plain queues and flags.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_tx_ovf, m_tx_unf, m_rx_ovf;
  int unsigned m_misroute;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] dest;
    bit tx_was_full, tx_was_empty, rx_was_full, rx_was_empty, acc;
    if (!reset) begin
      txq.delete(); rxq.delete();
      m_tx_ovf = 0; m_tx_unf = 0; m_rx_ovf = 0; m_misroute = 0;
      return;
    end
    tx_was_full  = (txq.size() == DEPTH_TX);
    tx_was_empty = (txq.size() == 0);
    if (pop && tx_was_empty) m_tx_unf = 1;
    if (wr_en && tx_was_full && !pop) m_tx_ovf = 1;
    if (pop && !tx_was_empty) void'(txq.pop_front());
    if (wr_en && (!tx_was_full || pop)) txq.push_back(wr_data);

    dest = D_push[31:24];
    acc  = push && (dest == MY_ID || dest == 8'hFF);
    if (push && !acc && m_misroute < 16'hFFFF) m_misroute++;
    rx_was_full  = (rxq.size() == DEPTH_RX);
    rx_was_empty = (rxq.size() == 0);
    if (acc && rx_was_full && !rx_rd) m_rx_ovf = 1;
    if (rx_rd && !rx_was_empty) void'(rxq.pop_front());
    if (acc && (!rx_was_full || rx_rd)) rxq.push_back(D_push);
  endtask

  task automatic check_all();
    chk("pndng",        32'(pndng),        32'(txq.size() != 0));
    chk("D_pop",        D_pop,             (txq.size() != 0) ? txq[0] : 32'h0);
    chk("tx_count",     32'(tx_count),     32'(txq.size()));
    chk("tx_full",      32'(tx_full),      32'(txq.size() == DEPTH_TX));
    chk("rx_valid",     32'(rx_valid),     32'(rxq.size() != 0));
    chk("rx_data",      rx_data,           (rxq.size() != 0) ? rxq[0] : 32'h0);
    chk("tx_overflow",  32'(tx_overflow),  32'(m_tx_ovf));
    chk("tx_underflow", 32'(tx_underflow), 32'(m_tx_unf));
    chk("rx_overflow",  32'(rx_overflow),  32'(m_rx_ovf));
    chk("misroute_cnt", 32'(misroute_cnt), m_misroute);
  endtask

  task automatic idle();
    wr_en = 0; pop = 0; push = 0; rx_rd = 0; reset = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_write(input logic [31:0] d);
    idle(); wr_en = 1; wr_data = d; cycle(); idle();
  endtask

  task automatic do_pop();
    idle(); pop = 1; cycle(); idle();
  endtask

  task automatic do_push(input logic [31:0] d);
    idle(); push = 1; D_push = d; cycle(); idle();
  endtask

  task automatic do_rd();
    idle(); rx_rd = 1; cycle(); idle();
  endtask

  initial begin
    idle(); wr_data = '0; D_push = '0;
    reset = 0;
    cycle(); cycle();
    idle();

    // Single write / pop with 1-cycle latency
    do_write(32'h0300_00AA);
    chk("first_D_pop", D_pop, 32'h0300_00AA);
    chk("first_count", 32'(tx_count), 32'd1);
    do_pop();
    chk("drained_D_pop", D_pop, 32'h0);

    // Fill TX, overflow, drain in order
    for (int i = 0; i < 8; i++) do_write(32'(i));
    do_write(32'hDEAD_0008);
    chk("tx_ovf_set", 32'(tx_overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("tx_order", D_pop, 32'(i));
      do_pop();
    end
    // Refill and write+pop while full
    for (int i = 0; i < 8; i++) do_write(32'h100 + 32'(i));
    idle(); wr_en = 1; wr_data = 32'h0000_0BEE; pop = 1; cycle(); idle();
    chk("full_wr_pop_count", 32'(tx_count), 32'd8);
    for (int i = 0; i < 8; i++) do_pop();

    // Write+pop on empty
    idle(); wr_en = 1; wr_data = 32'h1; pop = 1; cycle(); idle();
    chk("unf_D_pop", D_pop, 32'h1);
    chk("unf_flag", 32'(tx_underflow), 32'd1);
    do_pop();

    // RX filtering
    do_push(32'h0312_3456);
    do_push(32'hFF00_0001);
    do_push(32'h0500_0002);
    chk("rx_head", rx_data, 32'h0312_3456);
    chk("misroute_one", 32'(misroute_cnt), 32'd1);
    do_rd(); do_rd();
    do_rd(); // read while empty: no flag

    // RX fill, overflow, push+rd while full
    for (int i = 0; i < 8; i++) do_push({8'h03, 24'(i + 16)});
    do_push(32'hFF00_0099);
    chk("rx_ovf_set", 32'(rx_overflow), 32'd1);
    chk("rx_head_kept", rx_data, 32'h0300_0010);
    idle(); push = 1; D_push = 32'hFF00_0042; rx_rd = 1; cycle(); idle();
    for (int i = 0; i < 8; i++) do_rd();

    // Reset overriding simultaneous activity
    for (int i = 0; i < 4; i++) do_write(32'hA0 + 32'(i));
    for (int i = 0; i < 3; i++) do_push({8'h03, 24'(i)});
    idle(); reset = 0; wr_en = 1; wr_data = 32'h55; push = 1; D_push = 32'h0300_0077;
    cycle(); idle();
    chk("rst_count", 32'(tx_count), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned sel;
      idle();
      reset   = ($urandom_range(0, 199) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_data = $urandom;
      pop     = ($urandom_range(0, 2) == 0);
      push    = $urandom_range(0, 1);
      sel     = $urandom_range(0, 3);
      D_push  = $urandom;
      if (sel == 0) D_push[31:24] = MY_ID;
      else if (sel == 1) D_push[31:24] = 8'hFF;
      rx_rd   = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_terminal_port.md
Name: bus_terminal_port

Overview:
- Per-terminal endpoint sitting between a terminal agent and the bus generator/arbiter; one instance per bus terminal.
- TX side: buffers agent-written packets and presents them to the arbiter on pndng/D_pop/pop.
- RX side: consumes arbiter push/D_push, filters by destination ID (own ID or broadcast), and buffers accepted packets for the agent.
- Error/statistics flags and counters feed the scoreboard.

Parameters:
- ANCHO, 32, packet width in bits; destination ID in bits [ANCHO-1:ANCHO-8].
- PROFUNDIDAD, 8, TX FIFO depth in entries, >=2.
- RX_PROF, 8, RX FIFO depth in entries, >=2.
- ID, 0, this terminal's 8-bit address; must not equal BROADCAST.
- BROADCAST, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets all state.
- wr_en  in  1  agent write request into the TX FIFO.
- wr_data  in  ANCHO  packet written by the agent.
- tx_full  out  1  TX FIFO holds PROFUNDIDAD entries.
- tx_count  out  $clog2(PROFUNDIDAD+1)  TX occupancy.
- pndng  out  1  to arbiter: TX FIFO non-empty.
- D_pop  out  ANCHO  to arbiter: TX head entry, show-ahead.
- pop  in  1  from arbiter: consume TX head.
- push  in  1  from arbiter: D_push valid this cycle.
- D_push  in  ANCHO  packet delivered by the bus.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  ANCHO  RX head entry, show-ahead.
- rx_rd  in  1  agent consumes the RX head.
- tx_overflow  out  1  sticky: a write was dropped while full.
- tx_underflow  out  1  sticky: pop was asserted while empty.
- rx_overflow  out  1  sticky: an accepted packet was dropped because the RX FIFO was full.
- misroute_cnt  out  16  count of pushed packets whose ID is neither ID nor BROADCAST; saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0 at an edge): both FIFOs empty, pointers 0, all sticky flags 0, misroute_cnt 0.
- Reset values of outputs: pndng=0, tx_full=0, tx_count=0, rx_valid=0, D_pop=0, rx_data=0.
- Reset has priority over every simultaneous wr_en/pop/push/rx_rd; contents in flight are discarded.
- TX FIFO, circular buffer:
  - pndng = (tx_count!=0), registered-equivalent.
  - D_pop always equals the head entry; D_pop=0 when empty.
  - Write to empty: pndng=1 and D_pop valid the cycle after the write edge (1-cycle latency).
  - pop with pndng=1: head advances at that edge; the next entry appears on D_pop the following cycle.
- TX boundary cases:
  - wr_en with tx_full=1 and no pop: data dropped, tx_overflow set.
  - wr_en and pop both asserted while full: both take effect, count unchanged, no overflow.
  - pop while empty: ignored, tx_underflow set.
  - wr_en and pop both asserted while empty: write accepted, pop ignored, tx_underflow set.
  - Pointers wrap modulo PROFUNDIDAD; PROFUNDIDAD need not be a power of 2.
- RX filter:
  - On push, dest = D_push[ANCHO-1 -: 8].
  - dest==ID or dest==BROADCAST: packet accepted into the RX FIFO.
  - Otherwise: packet dropped, misroute_cnt incremented (saturating).
- RX FIFO: same show-ahead semantics as TX (rx_valid/rx_data/rx_rd).
  - Accepted push with RX full and no rx_rd: packet dropped, rx_overflow set.
  - Accepted push and rx_rd together while full: both take effect, no overflow.
  - rx_rd while empty: ignored; no flag is set.
- TX and RX paths are fully independent; any combination of same-cycle events is legal.
- Sticky flags clear only on reset.

Decomposition:
- Package bus_term_pkg holds:
  - ID_W=8
  - BROADCAST_ID=8'hFF
  - function get_dest(pkt), returning the top ID_W bits
  - CNT_W=16
- Sub-module port_fifo (params WIDTH, DEPTH):
  - show-ahead synchronous FIFO with ports push, pop, din, dout, count, full, empty, ovf_pulse, unf_pulse
  - instantiated twice, once for TX and once for RX.
- Top level contains only the ID filter, sticky flags and misroute counter.

Test Plan:
- Reset then ID=3: write 32'h0300_00AA -> next cycle pndng=1, D_pop=32'h0300_00AA, tx_count=1; pop -> next cycle pndng=0, D_pop=0.
- Write 8 packets 0..7 (PROFUNDIDAD=8), then 9th write -> tx_full=1, tx_overflow=1, 8 pops return 0..7 in order; next write+pop while full -> count stays 8, tx_overflow unchanged.
- Pop asserted on empty FIFO with simultaneous wr_en of 32'h1 -> tx_count=1, D_pop=1, tx_underflow=1.
- ID=3: push 32'h0312_3456, 32'hFF00_0001, 32'h0500_0002 -> rx FIFO holds 2 entries in order; misroute_cnt=1.
- Fill RX with 8 accepted pushes, 9th accepted push -> rx_overflow=1, rx_data still first packet; push+rx_rd together when full -> no loss, order preserved.
- TX holding 4 entries, RX holding 3 entries, reset=0 for one cycle coinciding with wr_en and push -> all counts 0, pndng=0, rx_valid=0, flags 0.
